sa_core: RTL and testbench
==========================

Name: sa_core

Overview:
- Output-stationary ROWS x ROWS systolic matrix-multiply core: C[r][c] = sum over k of A[r][k]*W[k][c], tile depth KLEN.
- Each beat supplies one k-slice:
  - activation column A[*][k] on ainport;
  - weight row W[k][*] on winport.
- Finished tiles go to a double-buffered result bank. Each row streams out its ROWS results, column 0 first, on its own routport lane.
- Sits between the operand feeders and the result writeback.

Parameters:
- ROWS, 8, array dimension (rows = columns = input lanes = output lanes).
- KLEN, 16, valid beats per tile; must be >= 2*ROWS-1.
- DW, 8, operand width, signed two's complement.
- ACCW, 32, accumulator/result width, signed.

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- ainport  in  [ROWS] x DW  unpacked array; lane r = A[r][k].
- winport  in  [ROWS] x DW  unpacked array; lane c = W[k][c].
- inpvalid  in  1  beat valid; sampled at rising edge; no backpressure.
- outread  in  1  pop one result from every row lane whose valid is high.
- routport  out  [ROWS] x ACCW  unpacked array; lane r = current head result of row r.
- rvalidport  out  [0:ROWS-1] packed  bit r high while row r holds unread results.

Behaviour:
- Reset (async, rstn=0): clears all of the following.
  - Skew registers, PE accumulators and PE result registers.
  - Beat counter and output bank.
  - rvalidport = 0 and routport = 0.
  - Reset mid-tile discards the partial tile and any undrained results.
- Beat acceptance: inpvalid=1 at an edge accepts one beat. The beat counter counts 0..KLEN-1 and wraps. The beat at count KLEN-1 is tagged "last". inpvalid=0 is a bubble: no accumulation and no count.
- Skew: lane r activation is delayed r cycles, then travels right one PE per cycle. Lane c weight is delayed c cycles, then travels down one PE per cycle. valid and last tags travel with the data.
- PE(r,c): on a valid operand pair, acc <= acc + a*w.
  - Product is signed DW x DW, sign-extended to ACCW. Accumulation wraps modulo 2^ACCW with no saturation.
  - On a last-tagged pair: res <= acc + a*w and acc <= 0 in the same edge. The next tile may start on the immediately following beat with no gap.
- Bank load: when PE(ROWS-1,ROWS-1) completes a tile, all PE res values are copied into the output bank. Every row pointer is set to column 0 and rvalidport goes all-ones.
  - The last-tagged beat accepted at edge E (back-to-back feeding) gives rvalidport high after edge E + 2*ROWS - 1.
  - KLEN >= 2*ROWS-1 guarantees that every res is stable at load time.
- Drain: routport[r] = bank[r][ptr_r], driven combinationally from registers.
  - outread=1 at an edge with rvalidport[r]=1 advances ptr_r.
  - After the pop of column ROWS-1, rvalidport[r] returns to 0 and routport[r] is 0.
  - outread with rvalidport=0 is ignored.
  - All rows load together, so they drain in lockstep.
- Overwrite: a bank load while results are still unread replaces the whole bank. Old data is dropped and pointers reset to 0. A load and a pop on the same edge resolve to the load (load wins).
- Compute proceeds concurrently with draining.

Decomposition:
- Package sa_pkg holds:
  - parameters ROWS, KLEN, DW, ACCW;
  - typedefs operand_t (logic signed [DW-1:0]) and acc_t (logic signed [ACCW-1:0]).
- One sub-module sa_pe holds:
  - the registered operand/tag pass-through (right and down);
  - the MAC and the accumulator/res registers;
  - a 2-D generate instantiates it.
- sa_core holds the skew shift registers, beat counter, bank and drain pointers.

Test Plan:
- All a=1, w=1, 16 back-to-back beats: rvalidport=8'hFF after 2*ROWS-1 cycles past the last beat edge; every row drains 8 values of 16 under outread=1.
- a lanes = beat index k (0..15), w=1: every result is 120. rvalidport[r] drops after exactly 8 pops.
- a=2, w_in[c]=c+1: row r streams 32, 64, ..., 256 in column order, with outread toggled 1/0 (valid holds between pops).
- Signed path: a=-1 (8'hFF), w=127 over 16 beats gives -2032 (32'hFFFF_F810) everywhere. a=-128, w=-128 gives 262144.
- Bubbles: 16 valid beats interleaved with inpvalid=0 give the same results as contiguous feeding. A tile of all 1s immediately followed by a tile of all 2s (w=1) with no outread: bank holds 32s; the first tile is lost.
- Reset: rstn low for 1 cycle after 8 beats, then a fresh 16-beat tile of 1s: results are 16 (no stale partial sums); rvalidport=0 throughout reset.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared sizing and operand/accumulator types for the systolic matmul core.
package sa_pkg;
  localparam int ROWS = 8;
  localparam int KLEN = 16;
  localparam int DW   = 8;
  localparam int ACCW = 32;

  localparam int CNTW = $clog2(KLEN);
  localparam int PTRW = $clog2(ROWS);

  typedef logic signed [DW-1:0]   operand_t;
  typedef logic signed [ACCW-1:0] acc_t;
endpackage

// File: rtl/sa_pe.sv
// Single processing element: registered operand/tag forwarding plus MAC.
module sa_pe
  import sa_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  operand_t i_a,
  input  operand_t i_w,
  input  logic     i_valid,
  input  logic     i_last,
  output operand_t o_a,
  output operand_t o_w,
  output logic     o_valid,
  output logic     o_last,
  output acc_t     o_res,
  output logic     o_done
);

  operand_t r_a;
  operand_t r_w;
  logic     r_valid;
  logic     r_last;
  acc_t     r_acc;
  acc_t     r_res;
  logic     r_done;
  acc_t     w_sum;

  // Full-width signed product; accumulation wraps modulo 2^ACCW.
  assign w_sum = r_acc + acc_t'(i_a) * acc_t'(i_w);

  // Forward operands and tags one hop, accumulate, and close the tile on last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a     <= '0;
      r_w     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_acc   <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_a     <= i_a;
      r_w     <= i_w;
      r_valid <= i_valid;
      r_last  <= i_valid & i_last;
      r_done  <= i_valid & i_last;
      if (i_valid) begin
        if (i_last) begin
          r_res <= w_sum;
          r_acc <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign o_a     = r_a;
  assign o_w     = r_w;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_res   = r_res;
  assign o_done  = r_done;

endmodule

// File: rtl/sa_core.sv
// Output-stationary ROWS x ROWS systolic matmul core with a drained result bank.
module sa_core
  import sa_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  operand_t        ainport [ROWS],
  input  operand_t        winport [ROWS],
  input  logic            inpvalid,
  input  logic            outread,
  output acc_t            routport [ROWS],
  output logic [0:ROWS-1] rvalidport
);

  logic [CNTW-1:0] r_beat;
  logic            w_beat_last;

  operand_t w_a_in [ROWS];
  logic     w_v_in [ROWS];
  logic     w_l_in [ROWS];
  operand_t w_w_in [ROWS];

  operand_t w_ah [ROWS][ROWS];
  operand_t w_wv [ROWS][ROWS];
  logic     w_vh [ROWS][ROWS];
  logic     w_lh [ROWS][ROWS];
  acc_t     w_res [ROWS][ROWS];
  logic     w_done [ROWS][ROWS];
  logic     w_load;

  acc_t            r_bank [ROWS][ROWS];
  logic [PTRW-1:0] r_ptr [ROWS];
  logic [0:ROWS-1] r_valid;

  assign w_beat_last = inpvalid && (r_beat == CNTW'(KLEN-1));

  // Beat counter tags the KLEN-th valid beat as last; bubbles do not count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat <= '0;
    end else if (inpvalid) begin
      r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
    end
  end

  // Lane i is delayed i cycles on both the activation and weight sides.
  for (genvar i = 0; i < ROWS; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign w_a_in[i] = ainport[i];
      assign w_v_in[i] = inpvalid;
      assign w_l_in[i] = w_beat_last;
      assign w_w_in[i] = winport[i];
    end else begin : g_delay
      operand_t r_a_sh [i];
      operand_t r_w_sh [i];
      logic     r_v_sh [i];
      logic     r_l_sh [i];

      // Shift register stage chain for lane i.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int s = 0; s < i; s++) begin
            r_a_sh[s] <= '0;
            r_w_sh[s] <= '0;
            r_v_sh[s] <= 1'b0;
            r_l_sh[s] <= 1'b0;
          end
        end else begin
          r_a_sh[0] <= ainport[i];
          r_w_sh[0] <= winport[i];
          r_v_sh[0] <= inpvalid;
          r_l_sh[0] <= w_beat_last;
          for (int s = 1; s < i; s++) begin
            r_a_sh[s] <= r_a_sh[s-1];
            r_w_sh[s] <= r_w_sh[s-1];
            r_v_sh[s] <= r_v_sh[s-1];
            r_l_sh[s] <= r_l_sh[s-1];
          end
        end
      end

      assign w_a_in[i] = r_a_sh[i-1];
      assign w_w_in[i] = r_w_sh[i-1];
      assign w_v_in[i] = r_v_sh[i-1];
      assign w_l_in[i] = r_l_sh[i-1];
    end
  end

  // Tags ride the activation path; weights flow down without tags.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < ROWS; c++) begin : g_col
      operand_t w_pe_a;
      operand_t w_pe_w;
      logic     w_pe_v;
      logic     w_pe_l;

      if (c == 0) begin : g_left
        assign w_pe_a = w_a_in[r];
        assign w_pe_v = w_v_in[r];
        assign w_pe_l = w_l_in[r];
      end else begin : g_inner_h
        assign w_pe_a = w_ah[r][c-1];
        assign w_pe_v = w_vh[r][c-1];
        assign w_pe_l = w_lh[r][c-1];
      end

      if (r == 0) begin : g_top
        assign w_pe_w = w_w_in[c];
      end else begin : g_inner_v
        assign w_pe_w = w_wv[r-1][c];
      end

      sa_pe u_pe (
        .clk     (clk),
        .rstn    (rstn),
        .i_a     (w_pe_a),
        .i_w     (w_pe_w),
        .i_valid (w_pe_v),
        .i_last  (w_pe_l),
        .o_a     (w_ah[r][c]),
        .o_w     (w_wv[r][c]),
        .o_valid (w_vh[r][c]),
        .o_last  (w_lh[r][c]),
        .o_res   (w_res[r][c]),
        .o_done  (w_done[r][c])
      );
    end
  end

  // The bottom-right PE finishes last, so its done flag means every res is final.
  assign w_load = w_done[ROWS-1][ROWS-1];

  // Bank load (wins over a same-edge pop) and per-row drain pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < ROWS; c++) r_bank[r][c] <= '0;
        r_ptr[r] <= '0;
      end
      r_valid <= '0;
    end else if (w_load) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < ROWS; c++) r_bank[r][c] <= w_res[r][c];
        r_ptr[r] <= '0;
      end
      r_valid <= '1;
    end else if (outread) begin
      for (int r = 0; r < ROWS; r++) begin
        if (r_valid[r]) begin
          if (r_ptr[r] == PTRW'(ROWS-1)) begin
            r_valid[r] <= 1'b0;
            r_ptr[r]   <= '0;
          end else begin
            r_ptr[r] <= r_ptr[r] + 1'b1;
          end
        end
      end
    end
  end

  // Head-of-row result, zero once the row is drained.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      routport[r] = r_valid[r] ? r_bank[r][r_ptr[r]] : '0;
    end
  end

  assign rvalidport = r_valid;

endmodule

// File: tb/tb_sa_core.sv
// Directed bench for sa_core with hand-computed tile results.
module tb_sa_core;
  import sa_pkg::*;

  logic            clk = 1'b0;
  logic            rstn;
  operand_t        ainport [ROWS];
  operand_t        winport [ROWS];
  logic            inpvalid;
  logic            outread;
  acc_t            routport [ROWS];
  logic [0:ROWS-1] rvalidport;

  int errors = 0;
  int checks = 0;

  sa_core dut (
    .clk        (clk),
    .rstn       (rstn),
    .ainport    (ainport),
    .winport    (winport),
    .inpvalid   (inpvalid),
    .outread    (outread),
    .routport   (routport),
    .rvalidport (rvalidport)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input operand_t a, input operand_t w, input bit ramp);
    for (int i = 0; i < ROWS; i++) begin
      ainport[i] = a;
      winport[i] = ramp ? operand_t'(int'(w) * (i + 1)) : w;
    end
  endtask

  // amode=1 drives every activation lane with the beat index.
  task automatic feed_tile(input bit amode, input operand_t a, input operand_t w,
                           input bit ramp, input bit bubbles);
    for (int k = 0; k < KLEN; k++) begin
      set_beat(amode ? operand_t'(k) : a, w, ramp);
      inpvalid = 1'b1;
      step();
      if (bubbles && k < KLEN - 1) begin
        set_beat(8'sh37, 8'sh5a, 1'b0);
        inpvalid = 1'b0;
        step();
      end
    end
    inpvalid = 1'b0;
    set_beat(8'sh13, 8'sh6c, 1'b0);
  endtask

  task automatic wait_load(input string tag);
    int n = 0;
    while (rvalidport == '0 && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(n), 32'(2 * ROWS - 1));
  endtask

  task automatic drain(input string tag, input acc_t base, input bit ramp, input bit toggle);
    for (int c = 0; c < ROWS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        check({tag, "_val"}, routport[r], ramp ? acc_t'(base * (c + 1)) : base);
      end
      check({tag, "_vld"}, 32'(rvalidport), 32'hFF);
      outread = 1'b1;
      step();
      if (toggle) begin
        outread = 1'b0;
        step();
        if (c < ROWS - 1) check({tag, "_hold"}, 32'(rvalidport), 32'hFF);
      end
    end
    outread = 1'b0;
    check({tag, "_empty"}, 32'(rvalidport), 32'h0);
    for (int r = 0; r < ROWS; r++) check({tag, "_zero"}, routport[r], 32'h0);
  endtask

  initial begin
    rstn     = 1'b0;
    inpvalid = 1'b0;
    outread  = 1'b0;
    set_beat(8'sh00, 8'sh00, 1'b0);
    #1;
    check("rst_vld", 32'(rvalidport), 32'h0);
    for (int r = 0; r < ROWS; r++) check("rst_out", routport[r], 32'h0);
    step();
    step();
    rstn = 1'b1;
    step();

    // ones x ones, continuous pop
    feed_tile(1'b0, 8'sd1, 8'sd1, 1'b0, 1'b0);
    wait_load("t1_lat");
    drain("t1", 32'sd16, 1'b0, 1'b0);

    // activation = beat index, sum 0..15
    feed_tile(1'b1, 8'sd0, 8'sd1, 1'b0, 1'b0);
    wait_load("t2_lat");
    drain("t2", 32'sd120, 1'b0, 1'b0);

    // column-dependent weights, toggled pops
    feed_tile(1'b0, 8'sd2, 8'sd1, 1'b1, 1'b0);
    wait_load("t3_lat");
    drain("t3", 32'sd32, 1'b1, 1'b1);

    // signed paths
    feed_tile(1'b0, -8'sd1, 8'sd127, 1'b0, 1'b0);
    wait_load("t4_lat");
    drain("t4", 32'hFFFF_F810, 1'b0, 1'b0);

    feed_tile(1'b0, -8'sd128, -8'sd128, 1'b0, 1'b0);
    wait_load("t5_lat");
    drain("t5", 32'sd262144, 1'b0, 1'b0);

    // bubbles between every beat
    feed_tile(1'b0, 8'sd1, 8'sd1, 1'b0, 1'b1);
    wait_load("t6_lat");
    drain("t6", 32'sd16, 1'b0, 1'b0);

    // back-to-back tiles without draining: second overwrites first
    feed_tile(1'b0, 8'sd1, 8'sd1, 1'b0, 1'b0);
    feed_tile(1'b0, 8'sd2, 8'sd1, 1'b0, 1'b0);
    check("t7_first_vld", 32'(rvalidport), 32'hFF);
    check("t7_first_val", routport[0], 32'd16);
    repeat (2 * ROWS - 2) step();
    check("t7_pre_load", routport[5], 32'd16);
    step();
    check("t7_post_load", routport[5], 32'd32);
    drain("t7", 32'sd32, 1'b0, 1'b0);

    // reset with pending results and a partial tile in flight
    feed_tile(1'b0, 8'sd1, 8'sd1, 1'b0, 1'b0);
    wait_load("t8_pre_lat");
    for (int k = 0; k < KLEN / 2; k++) begin
      set_beat(8'sd1, 8'sd1, 1'b0);
      inpvalid = 1'b1;
      step();
    end
    inpvalid = 1'b0;
    rstn = 1'b0;
    #1;
    check("t8_rst_vld", 32'(rvalidport), 32'h0);
    for (int r = 0; r < ROWS; r++) check("t8_rst_out", routport[r], 32'h0);
    step();
    check("t8_rst_vld2", 32'(rvalidport), 32'h0);
    rstn = 1'b1;
    step();
    feed_tile(1'b0, 8'sd1, 8'sd1, 1'b0, 1'b0);
    wait_load("t8_lat");
    drain("t8", 32'sd16, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
